// File: rtl/seq_pkg.sv
// Shared definitions for the 12-bit sequence-detect link.
// The generator and the detector both use these.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_gen_state_t;

    localparam int              SEQ_WIDTH   = 12;
    localparam logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 12'b1110_1101_1011;

endpackage : seq_pkg

// File: rtl/seq_piso.sv
// Parallel-load shift register.
// The MSB is always the next bit the generator will emit.
// A shift rotates the MSB back into the LSB, so after WIDTH shifts the
// register holds the loaded word again. Back-to-back copies therefore
// need no reload.
module seq_piso
    import seq_pkg::*;
#(
    parameter int               WIDTH = SEQ_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = SEQ_PATTERN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_i,
    output logic             serial_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    // Next contents: a load takes priority over a shift.
    always_comb begin
        // NOTE: give every always_comb output a default first, so that no path leaves it unassigned and infers a latch.
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = data_i;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        end
    end

    // Storage. Reset preloads the pattern so that a start on the first cycle after reset is already correct.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only; blocking ones would create ordering races between flops.
        if (reset) shreg_q <= INIT;
        else       shreg_q <= shreg_d;
    end

    assign serial_o = shreg_q[WIDTH-1];

endmodule : seq_piso

// File: rtl/sequence_generator.sv
// Serial pattern transmitter.
// It sends PATTERN MSB-first repeat_i times, with gap_i idle cycles
// between copies. done_o pulses for one cycle after the last bit.
// All outputs are registered.
module sequence_generator
    import seq_pkg::*;
#(
    parameter int               WIDTH   = SEQ_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = SEQ_PATTERN,
    parameter int               REP_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [REP_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             x_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    seq_gen_state_t   state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;   // index of the bit currently on x_o
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;   // copies still to finish, counting the current one
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;   // gap cycles remaining after the current one
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             piso_load, piso_shift, piso_bit;

    seq_piso #(
        .WIDTH (WIDTH),
        .INIT  (PATTERN)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (piso_load),
        .shift    (piso_shift),
        .data_i   (PATTERN),
        .serial_o (piso_bit)
    );

    // Next state and next registered outputs. Abort overrides everything.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        rep_cnt_d  = rep_cnt_q;
        gap_len_d  = gap_len_q;
        gap_cnt_d  = gap_cnt_q;
        x_d        = 1'b0;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;

        unique case (state_q)
            IDLE: begin
                piso_load = 1'b1;
                if (start_i && (repeat_i != '0)) begin
                    state_d    = SEND;
                    rep_cnt_d  = repeat_i;
                    gap_len_d  = gap_i;
                    bit_idx_d  = LAST_IDX;
                    piso_load  = 1'b0;
                    piso_shift = 1'b1;
                    x_d        = piso_bit;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            SEND: begin
                if (bit_idx_q != '0) begin
                    bit_idx_d  = bit_idx_q - 1'b1;
                    piso_shift = 1'b1;
                    x_d        = piso_bit;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    if (rep_cnt_q == REP_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (gap_len_q == '0) begin
                        bit_idx_d  = LAST_IDX;
                        piso_shift = 1'b1;
                        x_d        = piso_bit;
                        valid_d    = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q - 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end

            GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d    = SEND;
                    bit_idx_d  = LAST_IDX;
                    piso_shift = 1'b1;
                    x_d        = piso_bit;
                    valid_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Abort returns to IDLE and restores the pattern register, so the next start is aligned.
        if (abort_i) begin
            state_d    = IDLE;
            x_d        = 1'b0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            piso_load  = 1'b1;
            piso_shift = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_o     = x_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule : sequence_generator

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator.
// A queue holds the expected {x, valid, busy, done} for each cycle.
// A small behavioural detector on x_o counts pattern hits.
module tb_sequence_generator;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] repeat_i;
    logic [3:0] gap_i;
    logic       abort_i;
    logic       x_o, valid_o, busy_o, done_o;

    sequence_generator dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .repeat_i (repeat_i),
        .gap_i    (gap_i),
        .abort_i  (abort_i),
        .x_o      (x_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    logic [3:0]           exp_q[$];
    logic [SEQ_WIDTH-1:0] hist;
    logic                 det;
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt, done_cnt, det_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Push the per-cycle outputs expected for one complete run.
    task automatic push_run(input int rep, input int gap);
        logic [SEQ_WIDTH-1:0] pat;
        pat = SEQ_PATTERN;
        for (int c = 0; c < rep; c++) begin
            for (int b = SEQ_WIDTH - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            if (c != rep - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    // Advance one clock, then compare the DUT outputs with the next scoreboard entry.
    // When the queue is empty, the expected value is idle.
    task automatic cycle();
        logic [3:0] e;
        hist = {hist[SEQ_WIDTH-2:0], x_o};
        @(posedge clk);
        #1;
        det = (hist == SEQ_PATTERN);
        if (det)    det_cnt++;
        if (busy_o) busy_cnt++;
        if (done_o) done_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check("outputs{x,valid,busy,done}", {28'd0, x_o, valid_o, busy_o, done_o}, {28'd0, e});
        if (e[0]) check("det_with_done", {31'd0, det}, 32'd1);
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        done_cnt = 0;
        det_cnt  = 0;
    endtask

    task automatic start_run(input int rep, input int gap);
        start_i  = 1'b1;
        repeat_i = 8'(rep);
        gap_i    = 4'(gap);
        push_run(rep, gap);
        cycle();
        start_i  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset    = 1'b1;
        start_i  = 1'b0;
        repeat_i = '0;
        gap_i    = '0;
        abort_i  = 1'b0;
        hist     = '0;
        clear_counts();
        #1;
        check("reset_state", {28'd0, x_o, valid_o, busy_o, done_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(3);

        // Single copy, no gap.
        clear_counts();
        start_run(1, 0);
        idle_cycles(14);
        check("single_done_count", done_cnt, 1);
        check("single_busy_cycles", busy_cnt, 12);

        // Three copies separated by four idle cycles.
        clear_counts();
        start_run(3, 4);
        idle_cycles(46);
        check("gap_busy_cycles", busy_cnt, 44);
        check("gap_done_count", done_cnt, 1);
        check("gap_det_count", det_cnt, 3);

        // Loopback: five back-to-back copies give five detections, the last one together with done.
        clear_counts();
        start_run(5, 0);
        idle_cycles(62);
        check("loop_det_count", det_cnt, 5);
        check("loop_done_count", done_cnt, 1);

        // Maximum gap.
        clear_counts();
        start_run(2, 15);
        idle_cycles(42);
        check("gap15_busy_cycles", busy_cnt, 39);

        // A repeat count of zero is ignored.
        clear_counts();
        start_i = 1'b1; repeat_i = 8'd0; gap_i = 4'd2;
        cycle();
        start_i = 1'b0;
        idle_cycles(5);
        check("rep0_busy_cycles", busy_cnt, 0);

        // A start during a run is ignored.
        clear_counts();
        start_run(2, 1);
        idle_cycles(10);
        start_i = 1'b1; repeat_i = 8'd9; gap_i = 4'd7;
        cycle();
        start_i = 1'b0;
        idle_cycles(20);
        check("restart_busy_cycles", busy_cnt, 25);
        check("restart_done_count", done_cnt, 1);

        // Abort together with start in IDLE wins.
        clear_counts();
        start_i = 1'b1; abort_i = 1'b1; repeat_i = 8'd3; gap_i = 4'd0;
        cycle();
        start_i = 1'b0; abort_i = 1'b0;
        idle_cycles(4);
        check("abort_start_busy", busy_cnt, 0);

        // Abort while bit 5 of copy 2 of 4 is on x_o.
        clear_counts();
        start_run(4, 2);
        idle_cycles(12 + 2 + 6);
        exp_q.delete();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        idle_cycles(70);
        check("abort_done_count", done_cnt, 0);

        // The run after an abort is normal.
        clear_counts();
        start_run(2, 0);
        idle_cycles(26);
        check("post_abort_done", done_cnt, 1);
        check("post_abort_det", det_cnt, 2);

        // Reset asserted during SEND.
        clear_counts();
        start_run(3, 0);
        idle_cycles(5);
        reset = 1'b1;
        exp_q.delete();
        hist = '0;
        cycle();
        reset = 1'b0;
        idle_cycles(40);
        check("reset_mid_done", done_cnt, 0);

        // 255 copies: the repetition counter must not wrap.
        clear_counts();
        start_run(255, 0);
        idle_cycles(255 * 12 + 2);
        check("rep255_busy_cycles", busy_cnt, 255 * 12);
        check("rep255_det_count", det_cnt, 255);
        check("rep255_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sequence_generator
